// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-outstanding imem requests and
// hands instructions to the datapath. Optional macro FETCH_PERF_CNT_EN adds fetch/drop counters.
module fetch_unit #(
  parameter int               A_WIDTH  = 32,
  parameter int               I_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [I_WIDTH-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [I_WIDTH-1:0] instr,
  output logic [A_WIDTH-1:0] pc_out,
  output logic [4:0]         ad1,
  output logic [4:0]         ad2,
  output logic [4:0]         ad3,
  input  logic               redirect,
  input  logic [A_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        drop_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic [I_WIDTH-1:0] instr_q, instr_d;
  logic [A_WIDTH-1:0] pcOut_q, pcOut_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcOut_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcOut_q <= pcOut_d;
    end
  end

  // A redirect overrides every other event; an in-flight response becomes wrong-path.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcOut_d = pcOut_q;
    if (redirect) begin
      pc_d = redirect_pc & ~A_WIDTH'(3);
      unique case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = S_DROP;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
        S_VALID: state_d = S_REQ;
        S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            pcOut_d = pc_q;
            state_d = S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            pc_d    = pc_q + A_WIDTH'(4);
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_VALID);
  assign instr       = instr_q;
  assign pc_out      = pcOut_q;
  assign ad1         = instr_q[19:15];
  assign ad2         = instr_q[24:20];
  assign ad3         = instr_q[11:7];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCnt_q;
  logic [31:0] dropCnt_q;
  logic        dropEvt;

  assign dropEvt = imem_rvalid &
                   ((state_q == S_DROP) | ((state_q == S_WAIT) & redirect));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchCnt_q <= '0;
      dropCnt_q  <= '0;
    end else begin
      if (instr_valid & instr_ready) fetchCnt_q <= fetchCnt_q + 32'd1;
      if (dropEvt)                   dropCnt_q  <= dropCnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetchCnt_q;
  assign drop_cnt  = dropCnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random memory latency, backpressure and redirects,
// with a scoreboard of expected (pc, instruction) presentations.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [4:0]  ad1, ad2, ad3;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, drop_cnt;
`endif

  fetch_unit #(.A_WIDTH(32), .I_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc_out(pc_out),
    .ad1(ad1), .ad2(ad2), .ad3(ad3),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: next address to be presented, plus pending expectations.
  logic [31:0] curPc = RST_PC;
  logic [31:0] expQ[$];
  int          epoch = 0;
  bit          retired = 0;
  int          expFetch = 0;
  int          expDrop  = 0;

  // Memory model and stimulus knobs.
  int          pendCnt = 0;
  logic [31:0] pendAddr = '0;
  int          pendEpoch = 0;
  int          forceLat = 0;
  int          readyPct = 100;
  int          redirPct = 0;
  bit          forceRedir = 0;
  logic [31:0] forceTgt = '0;
  bit          checkFirst = 0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00A2_8293;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    logic        doRedir;
    logic [31:0] tgt;
    int          delivEpoch;
    int          r;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    delivEpoch  = pendEpoch;
    if (pendCnt > 0) begin
      pendCnt--;
      if (pendCnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memData(pendAddr);
      end
    end
    if (imem_req) begin
      checkOutput("single_outstanding", (pendCnt > 0 || imem_rvalid) ? 1 : 0, 0);
      pendCnt   = (forceLat != 0) ? forceLat : int'($urandom_range(1, 3));
      pendAddr  = imem_addr;
      pendEpoch = epoch;
    end
    instr_ready = ($urandom % 100) < readyPct;
    doRedir     = forceRedir || (($urandom % 100) < redirPct);
    r = $urandom % 4;
    case (r)
      0:       tgt = $urandom;
      1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      2:       tgt = 32'h0000_0103;
      default: tgt = 32'($urandom_range(0, 255));
    endcase
    if (forceRedir) tgt = forceTgt;
    forceRedir  = 0;
    redirect    = doRedir;
    redirect_pc = tgt;
    retired     = instr_valid && (instr_ready || doRedir);
    if (instr_valid && instr_ready) expFetch++;
    if (doRedir) begin
      epoch++;
      curPc = tgt & ~32'h3;
      expQ.delete();
      expQ.push_back(curPc);
    end else if (instr_valid && instr_ready) begin
      curPc = curPc + 32'd4;
      expQ.push_back(curPc);
    end
    if (imem_rvalid && delivEpoch != epoch) expDrop++;
  endtask

  task automatic step();
    @(posedge clk);
    #3;
    applyStimulus();
  endtask

  task automatic doReset(input int cycles);
    @(posedge clk);
    #3;
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    pendCnt     = 0;
    retired     = 0;
    expFetch    = 0;
    expDrop     = 0;
    epoch++;
    curPc = RST_PC;
    expQ.delete();
    expQ.push_back(curPc);
    repeat (cycles) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic waitValid(input int maxCycles, input string name);
    int n = 0;
    while (!instr_valid && n < maxCycles) begin
      step();
      n++;
    end
    if (!instr_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: no instr_valid within %0d cycles", name, maxCycles);
    end
  endtask

  task automatic waitReq(input int maxCycles, input string name);
    int n = 0;
    step();
    while (!imem_req && n < maxCycles) begin
      step();
      n++;
    end
    if (!imem_req) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: no imem_req within %0d cycles", name, maxCycles);
    end
  endtask

  // Monitor: pops the scoreboard on each new presentation and checks held outputs.
  int          sinceRst = 0;
  bit          prevValid = 0;
  bit          firstReqSeen = 0;
  logic [31:0] heldInstr = '0;
  logic [31:0] heldPc = '0;

  always begin
    bit          sampRst;
    logic [31:0] e;
    @(posedge clk);
    sampRst = !rst_n;
    #1;
    if (sampRst) begin
      checkOutput("reset_req", imem_req, 0);
      checkOutput("reset_valid", instr_valid, 0);
      checkOutput("reset_instr", instr, 0);
      checkOutput("reset_pc_out", pc_out, 0);
      sinceRst     = 0;
      prevValid    = 0;
      firstReqSeen = 0;
    end else begin
      sinceRst++;
      if (imem_req) begin
        checkOutput("req_addr", imem_addr, curPc);
        if (!firstReqSeen) begin
          firstReqSeen = 1;
          checkOutput("first_req_cycle", sinceRst, 1);
        end
      end
      if (instr_valid && !prevValid) begin
        checkOutput("req_during_valid", imem_req, 0);
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_instr: pc_out %h with no expectation", pc_out);
        end else begin
          e = expQ.pop_front();
          heldPc    = e;
          heldInstr = memData(e);
          checkOutput("pc_out", pc_out, heldPc);
          checkOutput("instr", instr, heldInstr);
          checkOutput("ad1", ad1, 32'(heldInstr[19:15]));
          checkOutput("ad2", ad2, 32'(heldInstr[24:20]));
          checkOutput("ad3", ad3, 32'(heldInstr[11:7]));
        end
        if (checkFirst) begin
          checkFirst = 0;
          checkOutput("first_valid_cycle", sinceRst, 3);
        end
      end else if (instr_valid && prevValid) begin
        checkOutput("valid_after_retire", retired, 0);
        checkOutput("hold_instr", instr, heldInstr);
        checkOutput("hold_pc_out", pc_out, heldPc);
        checkOutput("hold_no_req", imem_req, 0);
      end
      prevValid = instr_valid;
    end
  end

  initial begin
    expQ.push_back(curPc);

    // Reset release, 1-cycle memory, always ready.
    forceLat = 1; readyPct = 100; redirPct = 0; checkFirst = 1;
    doReset(3);
    repeat (30) step();

    // Backpressure for 5 cycles while an instruction is held.
    readyPct = 0;
    waitValid(20, "bp_wait");
    repeat (5) step();
    readyPct = 100;
    repeat (10) step();

    // Redirect while waiting; stale response arrives two cycles later.
    forceLat = 3;
    waitReq(20, "redir_wait_req");
    forceRedir = 1; forceTgt = 32'h0000_0103;
    step();
    forceLat = 1;
    repeat (20) step();

    // Redirect coincident with a handshake.
    readyPct = 0;
    waitValid(20, "redir_valid_wait");
    readyPct = 100; forceRedir = 1; forceTgt = 32'h0000_0040;
    step();
    repeat (15) step();

    // PC wrap at the top of the address space.
    readyPct = 0;
    waitValid(20, "wrap_wait");
    forceRedir = 1; forceTgt = 32'hFFFF_FFFE;
    step();
    readyPct = 100;
    repeat (20) step();

    // Reset while waiting on memory.
    forceLat = 3;
    waitReq(20, "rst_wait_req");
    step();
    doReset(2);
    forceLat = 1;
    repeat (20) step();

    // Random traffic.
    forceLat = 0; readyPct = 60; redirPct = 8;
    repeat (3000) step();
    redirPct = 0; readyPct = 100;
    repeat (20) step();

`ifdef FETCH_PERF_CNT_EN
    @(posedge clk);
    #1;
    checkOutput("fetch_cnt", fetch_cnt, expFetch);
    checkOutput("drop_cnt", drop_cnt, expDrop);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
